// File: rtl/calc_pkg.sv
// Shared calculator datapath types and sizing for the BCD encode/decode paths.
package calc_pkg;

  localparam int BCD_DIGITS = 6;
  localparam int BIN_WIDTH  = 21;
  localparam int CONV_STEPS = 20;
  localparam int CNT_W      = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } conv_state_e;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    logic                        sign;
    bcd_digit_t [BCD_DIGITS-1:0] digits;
  } signed_bcd_t;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_correct.sv
// One digit of the reverse double-dabble correction: digits of 8 or more
// lose 3 after the right shift so the next shift halves them correctly.
module bcd_digit_correct
  import calc_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential signed packed-BCD to binary converter, one shift/correct step
// per clock, with a start/busy/done handshake toward the operand entry logic.
//
//   state   | meaning
//   IDLE    | waiting for start; last result held
//   CONVERT | shifting BCD digits into the binary register, one bit per cycle
//   DONE    | result registers just updated; done high for this one cycle
module bcd_to_binary
  import calc_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [BCD_W:0]       bcdIn,
  output logic [BIN_WIDTH-1:0] binaryOut,
  output logic                 signOut,
  output logic                 busy,
  output logic                 done,
  output logic                 invalid
);

  conv_state_e        state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [19:0]        bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_sh;
  logic [BCD_W-1:0]   bcd_d;
  logic [19:0]        bin_d;
  signed_bcd_t        bcd_in_s;

  assign bcd_in_s = bcdIn;
  assign bcd_sh   = {1'b0, bcd_q[BCD_W-1:1]};
  assign bin_d    = {bcd_q[0], bin_q[19:1]};

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_corr
    bcd_digit_correct u_corr (
      .digit_i (bcd_sh[4*i +: 4]),
      .digit_o (bcd_d[4*i +: 4])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      binaryOut <= '0;
      signOut   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            signOut <= bcd_in_s.sign;
            bcd_q   <= bcd_in_s.digits;
            bin_q   <= '0;
            cnt_q   <= '0;
            if (has_bad_digit(bcd_in_s.digits)) begin
              // Bad digit: skip conversion and report a zero result at once.
              invalid   <= 1'b1;
              binaryOut <= '0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state_q   <= DONE;
            end else begin
              invalid <= 1'b0;
              busy    <= 1'b1;
              state_q <= CONVERT;
            end
          end
        end
        CONVERT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(CONV_STEPS - 1)) begin
            binaryOut <= {1'b0, bin_d};
            done      <= 1'b1;
            busy      <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: latency, handshake, invalid digits,
// ignored starts and asynchronous reset mid-conversion.
module tb_bcd_to_binary;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [24:0] bcdIn;
  logic [20:0] binaryOut;
  logic        signOut;
  logic        busy;
  logic        done;
  logic        invalid;

  int errors = 0;
  int checks = 0;

  bcd_to_binary dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .bcdIn     (bcdIn),
    .binaryOut (binaryOut),
    .signOut   (signOut),
    .busy      (busy),
    .done      (done),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done is seen or the budget runs out; n = edges taken,
  // b = cycles with busy high while done was still low.
  task automatic wait_done(input int budget, output int n, output int b);
    n = 0;
    b = 0;
    do begin
      step();
      n++;
      if (!done && busy) b++;
    end while (!done && n < budget);
  endtask

  task automatic do_conv(input string tag, input logic [24:0] v,
                         input logic [20:0] eb, input logic es);
    int n, b;
    start = 1'b1;
    bcdIn = v;
    step();
    start = 1'b0;
    chk({tag, ".busy_k"}, busy, 1);
    chk({tag, ".inv_k"}, invalid, 0);
    wait_done(40, n, b);
    chk({tag, ".latency"}, n, 20);
    chk({tag, ".busy_cycles"}, b + 1, 20);
    chk({tag, ".bin"}, binaryOut, eb);
    chk({tag, ".sign"}, signOut, es);
    chk({tag, ".invalid"}, invalid, 0);
    chk({tag, ".busy_done"}, busy, 0);
    step();
    chk({tag, ".done_once"}, done, 0);
    chk({tag, ".bin_hold"}, binaryOut, eb);
  endtask

  initial begin
    int n, b;
    resetn = 1'b0;
    start  = 1'b0;
    bcdIn  = '0;
    repeat (3) step();
    chk("rst.bin", binaryOut, 0);
    chk("rst.sign", signOut, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.inv", invalid, 0);
    @(negedge clk);
    resetn = 1'b1;
    step();

    do_conv("zero", 25'h0000000, 21'd0, 1'b0);
    do_conv("max", 25'h0999999, 21'h0F423F, 1'b0);

    // Start held continuously: second operand accepted on return to IDLE.
    start = 1'b1;
    bcdIn = 25'h1998001;
    step();
    bcdIn = 25'h0000123;
    chk("b2b.busy_k", busy, 1);
    wait_done(40, n, b);
    chk("b2b.lat1", n, 20);
    chk("b2b.bin1", binaryOut, 21'h0F3A71);
    chk("b2b.sign1", signOut, 1);
    step();
    chk("b2b.done_off", done, 0);
    chk("b2b.idle_busy", busy, 0);
    step();
    chk("b2b.accept2", busy, 1);
    chk("b2b.sign_hold", signOut, 0);
    wait_done(40, n, b);
    start = 1'b0;
    chk("b2b.lat2", n, 20);
    chk("b2b.bin2", binaryOut, 21'd123);
    chk("b2b.sign2", signOut, 0);
    step();

    // Invalid digit: straight to DONE, zero result.
    start = 1'b1;
    bcdIn = 25'h000A005;
    step();
    start = 1'b0;
    chk("inv.done", done, 1);
    chk("inv.flag", invalid, 1);
    chk("inv.bin", binaryOut, 0);
    chk("inv.busy", busy, 0);
    step();
    chk("inv.done_off", done, 0);
    chk("inv.hold", invalid, 1);
    step();
    do_conv("inv_clear", 25'h0000005, 21'd5, 1'b0);

    // A start during CONVERT must be ignored.
    start = 1'b1;
    bcdIn = 25'h0000042;
    step();
    start = 1'b0;
    repeat (4) step();
    start = 1'b1;
    bcdIn = 25'h0777777;
    step();
    start = 1'b0;
    wait_done(40, n, b);
    chk("ign.latency", n + 5, 20);
    chk("ign.bin", binaryOut, 21'd42);
    step();
    step();
    chk("ign.no_restart", busy, 0);

    // Asynchronous reset in the middle of a conversion.
    start = 1'b1;
    bcdIn = 25'h0999999;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("rstm.busy_before", busy, 1);
    #1;
    resetn = 1'b0;
    #1;
    chk("rstm.busy", busy, 0);
    chk("rstm.bin", binaryOut, 0);
    chk("rstm.done", done, 0);
    b = 0;
    repeat (12) begin
      step();
      if (done) b++;
    end
    chk("rstm.no_done", b, 0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk("rstm.idle", busy, 0);
    do_conv("after_rst", 25'h0000500, 21'd500, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
